// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI slave receive path: default word size, counter
// widths and the frame-length encoding that means "no frame limit".
// -----------------------------------------------------------------------------
package spi_pkg;

  // Default bits per received word.
  localparam int SPI_BITS_PER_WORD = 8;

  // Width of the per-word bit counter. Must hold SPI_BITS_PER_WORD.
  localparam int SPI_BIT_W = 4;

  // Width of the word counter and of the programmed frame length.
  localparam int SPI_WORD_W = 8;

  // A frame length of this value disables frame_done entirely.
  localparam int FRAME_UNBOUNDED = 0;

endpackage : spi_pkg

// File: rtl/spi_bit_downcounter.sv
// -----------------------------------------------------------------------------
// spi_bit_downcounter
// Loadable down counter used to count the bits remaining in a serial word.
//   - load forces the counter back to RELOAD_VAL and takes priority over en.
//   - en with count > 1 decrements.
//   - en with count == 1 is the terminal step: the counter either reloads
//     (reload_on_tc = 1) or parks at zero.
//   - en with count == 0 holds (stop-at-zero).
//
// Ports:
//   clk           in   counting clock, all updates on posedge
//   rst           in   synchronous active-high reset, returns to RELOAD_VAL
//   load          in   re-arm to RELOAD_VAL, overrides en
//   en            in   consume one bit this edge
//   reload_on_tc  in   action at terminal count: 1 = reload, 0 = stop at zero
//   count         out  registered bits remaining
//   tc            out  combinational strobe: this edge consumes the last bit
// -----------------------------------------------------------------------------
module spi_bit_downcounter
  import spi_pkg::*;
#(
  parameter int BIT_W      = SPI_BIT_W,
  parameter int RELOAD_VAL = SPI_BITS_PER_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             reload_on_tc,
  output logic [BIT_W-1:0] count,
  output logic             tc
);

  localparam logic [BIT_W-1:0] RELOAD = BIT_W'(RELOAD_VAL);
  localparam logic [BIT_W-1:0] ONE    = BIT_W'(1);

  logic [BIT_W-1:0] count_q;
  logic [BIT_W-1:0] count_d;

  // Terminal strobe is suppressed by load so the owner never sees a
  // word-complete event on an edge where the counter is being re-armed.
  assign tc = en && !load && (count_q == ONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the if/else tree leaves it unassigned and infers a latch.
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (en) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else if (count_q == ONE) begin
        count_d = reload_on_tc ? RELOAD : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of block evaluation order.
    if (rst) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : spi_bit_downcounter

// File: rtl/spi_rx_frame_counter.sv
// -----------------------------------------------------------------------------
// spi_rx_frame_counter
// Counts received bits per word on the serial clock and completed words per
// frame for the SPI slave RX path. Emits a one-cycle word_done pulse after the
// last bit of each word and a sticky frame_done once the programmed number of
// words has arrived. Edge priority: rstRX > load > decRx.
//
// Ports:
//   sck          in   serial clock, all state updates on posedge
//   rstRX        in   synchronous active-high reset
//   decRx        in   bit-received strobe, one bit per edge while high
//   load         in   start a new frame: latch frame_len, re-arm counters
//   frame_len    in   words per frame sampled on load, 0 = unbounded
//   auto_reload  in   1 = reload bit counter after each word, 0 = stop at 0
//   bit_count    out  bits remaining in the current word
//   word_count   out  words completed in the current frame (saturating)
//   word_done    out  registered one-cycle pulse after a word's last bit
//   frame_done   out  sticky, set when word_count reaches frame_len
//   busy         out  bit_count != 0 and frame not done (combinational)
// -----------------------------------------------------------------------------
module spi_rx_frame_counter
  import spi_pkg::*;
#(
  parameter int BITS_PER_WORD = SPI_BITS_PER_WORD,
  parameter int BIT_W         = SPI_BIT_W,
  parameter int WORD_W        = SPI_WORD_W
) (
  input  logic              sck,
  input  logic              rstRX,
  input  logic              decRx,
  input  logic              load,
  input  logic [WORD_W-1:0] frame_len,
  input  logic              auto_reload,
  output logic [BIT_W-1:0]  bit_count,
  output logic [WORD_W-1:0] word_count,
  output logic              word_done,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [WORD_W-1:0] WORD_MAX  = '1;
  localparam logic [WORD_W-1:0] UNBOUNDED = WORD_W'(FRAME_UNBOUNDED);

  logic [WORD_W-1:0] word_count_q, word_count_d;
  logic [WORD_W-1:0] frame_len_q,  frame_len_d;
  logic              word_done_q,  word_done_d;
  logic              frame_done_q, frame_done_d;

  logic              last_bit;
  logic              frame_hit;
  logic [WORD_W:0]   word_count_inc;

  // One bit wider than the counter so a saturated word_count can never wrap
  // around and falsely match a short frame length.
  assign word_count_inc = {1'b0, word_count_q} + {{WORD_W{1'b0}}, 1'b1};
  assign frame_hit      = (frame_len_q != UNBOUNDED)
                       && (word_count_inc == {1'b0, frame_len_q});

  // Once frame_done is set the bit counter is parked at zero; gating the
  // enable as well keeps the frame frozen against any further strobes.
  spi_bit_downcounter #(
    .BIT_W      (BIT_W),
    .RELOAD_VAL (BITS_PER_WORD)
  ) u_bit_cnt (
    .clk          (sck),
    .rst          (rstRX),
    .load         (load),
    .en           (decRx && !frame_done_q),
    .reload_on_tc (auto_reload && !frame_hit),
    .count        (bit_count),
    .tc           (last_bit)
  );

  always_comb begin
    word_count_d = word_count_q;
    frame_len_d  = frame_len_q;
    frame_done_d = frame_done_q;
    word_done_d  = 1'b0;
    if (load) begin
      word_count_d = '0;
      frame_len_d  = frame_len;
      frame_done_d = 1'b0;
    end else if (last_bit) begin
      word_done_d = 1'b1;
      if (word_count_q != WORD_MAX) begin
        word_count_d = word_count_inc[WORD_W-1:0];
      end
      if (frame_hit) begin
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sck) begin
    if (rstRX) begin
      word_count_q <= '0;
      frame_len_q  <= '0;
      word_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      frame_len_q  <= frame_len_d;
      word_done_q  <= word_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign word_count = word_count_q;
  assign word_done  = word_done_q;
  assign frame_done = frame_done_q;
  assign busy       = (bit_count != '0) && !frame_done_q;

endmodule : spi_rx_frame_counter

// File: tb/tb_spi_rx_frame_counter.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_frame_counter
// Self-checking bench for spi_rx_frame_counter. A small integer model of the
// counter's rules tracks expected outputs edge by edge; directed scenarios are
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_spi_rx_frame_counter;

  localparam int BPW      = 8;
  localparam int BIT_W    = 4;
  localparam int WORD_W   = 8;
  localparam int WORD_SAT = (1 << WORD_W) - 1;

  logic              sck;
  logic              rstRX;
  logic              decRx;
  logic              load;
  logic [WORD_W-1:0] frame_len;
  logic              auto_reload;
  logic [BIT_W-1:0]  bit_count;
  logic [WORD_W-1:0] word_count;
  logic              word_done;
  logic              frame_done;
  logic              busy;

  spi_rx_frame_counter #(
    .BITS_PER_WORD (BPW),
    .BIT_W         (BIT_W),
    .WORD_W        (WORD_W)
  ) dut (
    .sck         (sck),
    .rstRX       (rstRX),
    .decRx       (decRx),
    .load        (load),
    .frame_len   (frame_len),
    .auto_reload (auto_reload),
    .bit_count   (bit_count),
    .word_count  (word_count),
    .word_done   (word_done),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  int n_checks = 0;
  int n_passed = 0;
  string phase = "init";

  // Reference model state, in plain integers.
  int m_bits  = BPW;
  int m_words = 0;
  int m_flen  = 0;
  bit m_wdone = 0;
  bit m_fdone = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
  endtask

  // Apply the counter rules for one edge using the inputs currently driven.
  task automatic model_edge();
    int nw;
    if (rstRX) begin
      m_bits = BPW; m_words = 0; m_flen = 0; m_wdone = 0; m_fdone = 0;
    end else if (load) begin
      m_bits = BPW; m_words = 0; m_flen = int'(frame_len); m_wdone = 0; m_fdone = 0;
    end else if (decRx && !m_fdone && m_bits > 1) begin
      m_bits--; m_wdone = 0;
    end else if (decRx && !m_fdone && m_bits == 1) begin
      m_wdone = 1;
      nw = m_words + 1;
      m_words = (nw > WORD_SAT) ? WORD_SAT : nw;
      if (m_flen != 0 && nw == m_flen) begin
        m_fdone = 1; m_bits = 0;
      end else begin
        m_bits = auto_reload ? BPW : 0;
      end
    end else begin
      m_wdone = 0;
    end
  endtask

  task automatic check_all();
    check("bit_count",  32'(bit_count),  32'(m_bits));
    check("word_count", 32'(word_count), 32'(m_words));
    check("word_done",  32'(word_done),  32'(m_wdone));
    check("frame_done", 32'(frame_done), 32'(m_fdone));
    check("busy",       32'(busy),       32'(m_bits != 0 && !m_fdone));
  endtask

  // One clock edge: DUT and model both consume the current inputs, outputs
  // are compared 1 ns after the edge.
  task automatic tick();
    @(posedge sck);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic dec_n(input int n);
    decRx = 1'b1;
    for (int i = 0; i < n; i++) tick();
    decRx = 1'b0;
  endtask

  task automatic do_load(input int flen, input bit ar);
    load = 1'b1; frame_len = WORD_W'(flen); auto_reload = ar;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rstRX = 1'b1; decRx = 1'b0; load = 1'b0; frame_len = '0; auto_reload = 1'b0;
    #2;

    phase = "reset";
    tick();
    check("rst_bits", 32'(bit_count), 32'(BPW));
    check("rst_busy", 32'(busy), 32'd1);
    rstRX = 1'b0;

    phase = "single_word_stop";
    auto_reload = 1'b0;
    dec_n(8);
    check("tp1_bits_zero", 32'(bit_count), 32'd0);
    check("tp1_wdone", 32'(word_done), 32'd1);
    check("tp1_words", 32'(word_count), 32'd1);
    dec_n(3);
    check("tp1_hold_bits", 32'(bit_count), 32'd0);
    check("tp1_wdone_drop", 32'(word_done), 32'd0);

    phase = "frame3_reload";
    do_load(3, 1'b1);
    dec_n(24);
    check("tp2_fdone", 32'(frame_done), 32'd1);
    check("tp2_words", 32'(word_count), 32'd3);
    check("tp2_busy", 32'(busy), 32'd0);

    phase = "frozen_then_reload";
    dec_n(5);
    check("tp3_frozen_words", 32'(word_count), 32'd3);
    do_load(1, 1'b1);
    check("tp3_fdone_clr", 32'(frame_done), 32'd0);
    check("tp3_bits", 32'(bit_count), 32'(BPW));

    phase = "reset_on_last_bit";
    dec_n(7);
    check("tp4_pre_bits", 32'(bit_count), 32'd1);
    rstRX = 1'b1; decRx = 1'b1;
    tick();
    rstRX = 1'b0; decRx = 1'b0;
    check("tp4_no_wdone", 32'(word_done), 32'd0);

    phase = "load_beats_dec";
    dec_n(3);
    load = 1'b1; decRx = 1'b1; frame_len = 8'd2; auto_reload = 1'b0;
    tick();
    load = 1'b0; decRx = 1'b0;
    check("tp5_bits", 32'(bit_count), 32'(BPW));

    phase = "saturate";
    do_load(0, 1'b1);
    dec_n(256 * 8 + 8);
    check("tp6_words_sat", 32'(word_count), 32'(WORD_SAT));
    check("tp6_fdone", 32'(frame_done), 32'd0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      rstRX       = ($urandom_range(63) == 0);
      load        = ($urandom_range(15) == 0);
      frame_len   = WORD_W'($urandom_range(4));
      decRx       = ($urandom_range(3) != 0);
      auto_reload = ($urandom_range(3) != 0);
      tick();
    end
    rstRX = 1'b0; load = 1'b0; decRx = 1'b0;

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule : tb_spi_rx_frame_counter
